// File: rtl/ecall_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ecall_pkg                                                     |
// | Purpose  : Shared constants and FSM state type for the ecall responder.  |
// |            Holds the service numbers decoded from a7, the ecall          |
// |            instruction encoding and the controller state enum.           |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package ecall_pkg;

   // Service numbers carried in a7 (x17); compared at full 32-bit width
   localparam logic [31:0] SVC_PRINT_INT = 32'd1;
   localparam logic [31:0] SVC_READ_INT  = 32'd5;
   localparam logic [31:0] SVC_EXIT      = 32'd10;

   // Instruction word the decoder matches before raising ecall_valid
   localparam logic [31:0] ECALL_INSN    = 32'h0000_0073;

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_WAIT_PRESS   = 3'd1,
      ST_WAIT_RELEASE = 3'd2,
      ST_DONE         = 3'd3,
      ST_HALT         = 3'd4
   } ecall_state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : btn_debounce                                                  |
// | Purpose  : Stable-level counter for a raw push button. Counts consecutive|
// |            cycles on which btn_in equals level_target and flags the      |
// |            cycle on which the run reaches DEBOUNCE_CYCLES.               |
// | Ports    : clk, reset        - clock, async active-high reset            |
// |            clr               - hold counter at zero                      |
// |            level_target      - level being waited for (1=press,0=release)|
// |            btn_in            - raw button                                |
// |            stable_pulse      - high on the DEBOUNCE_CYCLES-th stable cycle|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic level_target,
   input  logic btn_in,
   output logic stable_pulse
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic             at_level;

   assign at_level = (btn_in == level_target);

   // The counter holds the number of stable cycles already seen, so the
   // current cycle completes the run when it sits at DEBOUNCE_CYCLES-1.
   // With DEBOUNCE_CYCLES=1 this accepts on the first matching sample.
   assign stable_pulse = !clr && at_level && (cnt == CNT_LAST);

   // Restart on any mismatch and after a completed run so the next phase
   // starts counting from zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr || !at_level || (cnt == CNT_LAST)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/ecall_io_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ecall_io_ctrl                                                 |
// | Purpose  : Responder for the CPU ecall path. Services PRINT_INT (a7=1),  |
// |            READ_INT (a7=5, switches confirmed by a debounced button),    |
// |            EXIT (a7=10) and treats any other a7 as a no-op. Stalls the   |
// |            core while a call is in progress.                             |
// | Config   : ECALL_SIGNEXT_EN - when defined READ_INT sign-extends the     |
// |            switch value to 32 bits, otherwise it zero-extends.           |
// | Ports    : clk, reset        - clock, async active-high reset            |
// |            ecall_valid       - ecall in decode, held while stall=1       |
// |            a7, a0            - service number / argument                 |
// |            switch            - board switches                            |
// |            confirm_btn       - raw confirm button                        |
// |            stall             - freeze PC and register writes             |
// |            wb_en, wb_data    - one-cycle write of read result into x10   |
// |            disp_data         - last printed value                        |
// |            disp_valid        - a print has happened since reset          |
// |            halted            - sticky after EXIT                         |
// |            done              - one-cycle completion pulse                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ecall_io_ctrl
   import ecall_pkg::*;
#(
   parameter int SW_W            = 16,
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ecall_valid,
   input  logic [31:0]     a7,
   input  logic [31:0]     a0,
   input  logic [SW_W-1:0] switch,
   input  logic            confirm_btn,
   output logic            stall,
   output logic            wb_en,
   output logic [31:0]     wb_data,
   output logic [31:0]     disp_data,
   output logic            disp_valid,
   output logic            halted,
   output logic            done
);

   ecall_state_t state;
   logic         svc_read;      // call being serviced is READ_INT
   logic         deb_clr;
   logic         deb_target;
   logic         deb_stable;
   logic [31:0]  sw_ext;

   // The debouncer only counts in the two button phases; everywhere else it
   // is held clear so each READ_INT starts from zero.
   assign deb_clr    = !((state == ST_WAIT_PRESS) || (state == ST_WAIT_RELEASE));
   assign deb_target = (state == ST_WAIT_PRESS);

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk          (clk),
      .reset        (reset),
      .clr          (deb_clr),
      .level_target (deb_target),
      .btn_in       (confirm_btn),
      .stable_pulse (deb_stable)
   );

   always_comb begin
      sw_ext             = '0;
      sw_ext[SW_W-1:0]   = switch;
`ifdef ECALL_SIGNEXT_EN
      for (int i = SW_W; i < 32; i++) begin
         sw_ext[i] = switch[SW_W-1];
      end
`endif
   end

   // Stall must be visible in the same cycle the ecall arrives, hence the
   // combinational IDLE term. DONE releases the PC.
   assign stall = ((state == ST_IDLE) && ecall_valid) ||
                  (state == ST_WAIT_PRESS)            ||
                  (state == ST_WAIT_RELEASE)          ||
                  (state == ST_HALT);

   assign done  = (state == ST_DONE);
   assign wb_en = (state == ST_DONE) && svc_read;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         svc_read   <= 1'b0;
         wb_data    <= '0;
         disp_data  <= '0;
         disp_valid <= 1'b0;
         halted     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ecall_valid) begin
                  svc_read <= (a7 == SVC_READ_INT);
                  if (a7 == SVC_PRINT_INT) begin
                     disp_data  <= a0;
                     disp_valid <= 1'b1;
                     state      <= ST_DONE;
                  end else if (a7 == SVC_READ_INT) begin
                     state <= ST_WAIT_PRESS;
                  end else if (a7 == SVC_EXIT) begin
                     halted <= 1'b1;
                     state  <= ST_HALT;
                  end else begin
                     state <= ST_DONE;
                  end
               end
            end
            ST_WAIT_PRESS: begin
               if (deb_stable) begin
                  wb_data <= sw_ext;
                  state   <= ST_WAIT_RELEASE;
               end
            end
            ST_WAIT_RELEASE: begin
               if (deb_stable) begin
                  state <= ST_DONE;
               end
            end
            // ecall_valid is still the same instruction here; ignore it
            ST_DONE: state <= ST_IDLE;
            ST_HALT: state <= ST_HALT;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
